// File: rtl/bit_stream_serializer_pkg.sv
// Shared definitions for the bit stream serializer: FSM state encoding,
// default word width and the derivation of bits sent per word.
// Optional feature macro: SER_PARITY_EN (appends one even-parity bit per word).
package ser_pkg;

    // Raw state encodings, kept as named constants so the enum below is pinned.
    localparam logic S_IDLE_ENC  = 1'b0;
    localparam logic S_SHIFT_ENC = 1'b1;

    // Serializer FSM states: waiting for a word, or presenting bits on w.
    typedef enum logic {
        S_IDLE  = S_IDLE_ENC,
        S_SHIFT = S_SHIFT_ENC
    } serState_e;

    // Word width used when the instantiating code does not override it.
    localparam int SER_DEFAULT_WIDTH = 8;

    // Number of serial bits emitted per accepted word.
    function automatic int serNBits(input int width);
`ifdef SER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/bit_stream_serializer_if.sv
// Interface bundling the word-input handshake and the serial output of the
// bit stream serializer. The master side feeds words and watches the line;
// the slave side is the serializer itself.
interface bit_stream_serializer_if
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             w;
    logic             w_valid;
    logic             busy;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  w,
        input  w_valid,
        input  busy
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output w,
        output w_valid,
        output busy
    );

endinterface

// File: rtl/bit_stream_serializer_bit_counter.sv
// Bit position counter for the serializer. Clearing restarts a word at bit 0,
// incrementing advances one bit, and tc_o flags the final bit of the word.
// The count saturates at the final position instead of wrapping.
module ser_bit_counter #(
    parameter int NBITS = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic inc_i,
    output logic tc_o
);

    localparam int CNT_W = (NBITS > 1) ? $clog2(NBITS) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NBITS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins over increment, and the count never passes LAST.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Count register, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == LAST);

endmodule

// File: rtl/bit_stream_serializer.sv
// Bit stream serializer: accepts WIDTH-bit words over valid/ready and sends
// them MSB-first on w, one bit per clock. A one-word holding register lets
// consecutive words follow each other with no idle cycle, so bit patterns
// spanning word boundaries reach the downstream detector intact.
// Optional feature macro: SER_PARITY_EN (even-parity bit sent after the LSB).
module bit_stream_serializer
    import ser_pkg::*;
#(
    parameter int WIDTH = SER_DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    bit_stream_serializer_if.slave  bus
);

    localparam int NBITS = serNBits(WIDTH);

    serState_e        state_q;
    serState_e        state_d;
    logic [NBITS-1:0] shiftReg_q;
    logic [NBITS-1:0] shiftReg_d;
    logic [WIDTH-1:0] holdData_q;
    logic [WIDTH-1:0] holdData_d;
    logic             holdFull_q;
    logic             holdFull_d;

    logic             accept;
    logic             cntClear;
    logic             cntInc;
    logic             cntTc;

    // Build the shifter image of a word: data MSB-first, parity last if enabled.
    function automatic logic [NBITS-1:0] packWord(input logic [WIDTH-1:0] word);
`ifdef SER_PARITY_EN
        return {word, ^word};
`else
        return word;
`endif
    endfunction

    ser_bit_counter #(
        .NBITS (NBITS)
    ) u_bitCounter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cntClear),
        .inc_i   (cntInc),
        .tc_o    (cntTc)
    );

    // Next-state logic: word acceptance into the hold register and the shifter FSM.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        holdData_d = holdData_q;
        holdFull_d = holdFull_q;
        cntClear   = 1'b0;
        cntInc     = 1'b0;

        // Acceptance only happens while the hold register is empty, so it can
        // never coincide with the hold-to-shifter move below.
        accept = bus.in_valid && !holdFull_q;
        if (accept) begin
            holdData_d = bus.in_data;
            holdFull_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (holdFull_q) begin
                    shiftReg_d = packWord(holdData_q);
                    holdFull_d = 1'b0;
                    cntClear   = 1'b1;
                    state_d    = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cntTc) begin
                    if (holdFull_q) begin
                        shiftReg_d = packWord(holdData_q);
                        holdFull_d = 1'b0;
                        cntClear   = 1'b1;
                    end else begin
                        shiftReg_d = '0;
                        state_d    = S_IDLE;
                    end
                end else begin
                    shiftReg_d = {shiftReg_q[NBITS-2:0], 1'b0};
                    cntInc     = 1'b1;
                end
            end
            default: begin
                shiftReg_d = '0;
                state_d    = S_IDLE;
            end
        endcase
    end

    // State, shifter and hold registers; reset discards any word in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            shiftReg_q <= '0;
            holdData_q <= '0;
            holdFull_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            holdData_q <= holdData_d;
            holdFull_q <= holdFull_d;
        end
    end

    // Outputs come straight from registers; w is forced low outside SHIFT.
    assign bus.in_ready = !holdFull_q;
    assign bus.w_valid  = (state_q == S_SHIFT);
    assign bus.w        = (state_q == S_SHIFT) && shiftReg_q[NBITS-1];
    assign bus.busy     = (state_q == S_SHIFT) || holdFull_q;

endmodule

// File: tb/tb_bit_stream_serializer.sv
// Directed testbench for bit_stream_serializer: reset behaviour, single-word
// latency and bit order, back-to-back streaming, reset mid-word, input
// ignored while not ready, and (when SER_PARITY_EN is defined) parity bits.
module tb_bit_stream_serializer;
    import ser_pkg::*;

    localparam int WIDTH = 8;
    localparam int NB    = serNBits(WIDTH);

`ifdef SER_PARITY_EN
    localparam logic [NB-1:0] EXP_F0  = 9'b1111_0000_0;
    localparam logic [NB-1:0] EXP_0F  = 9'b0000_1111_0;
    localparam logic [NB-1:0] EXP_80  = 9'b1000_0000_1;
    localparam logic [NB-1:0] EXP_A5  = 9'b1010_0101_0;
    localparam logic [NB-1:0] EXP_3C  = 9'b0011_1100_0;
    localparam logic [NB-1:0] EXP_F1  = 9'b1111_0001_1;
    localparam int            MAX_RUN = 4;
`else
    localparam logic [NB-1:0] EXP_F0  = 8'b1111_0000;
    localparam logic [NB-1:0] EXP_0F  = 8'b0000_1111;
    localparam logic [NB-1:0] EXP_80  = 8'b1000_0000;
    localparam logic [NB-1:0] EXP_A5  = 8'b1010_0101;
    localparam logic [NB-1:0] EXP_3C  = 8'b0011_1100;
    localparam int            MAX_RUN = 8;
`endif

    logic clk;
    logic reset;
    int   compareCount = 0;
    int   failCount    = 0;

    bit_stream_serializer_if #(.WIDTH(WIDTH)) serIf ();

    bit_stream_serializer #(
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (serIf)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reset held for 10 ns, then idle outputs checked for several cycles.
    task automatic test_reset();
        #1;
        compareCount++;
        if (serIf.w !== 1'b0 || serIf.w_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_during: w=%b w_valid=%b want 0 0", serIf.w, serIf.w_valid);
        end
        #9 reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            compareCount++;
            if (serIf.w !== 1'b0 || serIf.w_valid !== 1'b0 ||
                serIf.in_ready !== 1'b1 || serIf.busy !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL reset_idle[%0d]: w=%b w_valid=%b in_ready=%b busy=%b want 0 0 1 0",
                         i, serIf.w, serIf.w_valid, serIf.in_ready, serIf.busy);
            end
        end
    endtask

    // One word 8'hF0: latency, bit order, return to idle, one 1111 detection.
    task automatic test_single();
        int         yCount;
        logic [3:0] hist;
        yCount = 0;
        hist   = '0;
        @(negedge clk);
        compareCount++;
        if (serIf.in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL single_ready: got %b want 1", serIf.in_ready);
        end
        serIf.in_valid = 1'b1;
        serIf.in_data  = 8'hF0;
        @(posedge clk);
        #1;
        serIf.in_valid = 1'b0;
        serIf.in_data  = 8'h00;
        @(negedge clk);
        compareCount++;
        if (serIf.w_valid !== 1'b0 || serIf.busy !== 1'b1 || serIf.in_ready !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_latency: w_valid=%b busy=%b in_ready=%b want 0 1 0",
                     serIf.w_valid, serIf.busy, serIf.in_ready);
        end
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            compareCount++;
            if (serIf.w !== EXP_F0[NB-1-i] || serIf.w_valid !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL single_bit[%0d]: w=%b w_valid=%b want %b 1",
                         i, serIf.w, serIf.w_valid, EXP_F0[NB-1-i]);
            end
            hist = {hist[2:0], serIf.w};
            if (hist == 4'hF) yCount++;
        end
        @(negedge clk);
        compareCount++;
        if (serIf.w !== 1'b0 || serIf.w_valid !== 1'b0 || serIf.busy !== 1'b0 || serIf.in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL single_end: w=%b w_valid=%b busy=%b in_ready=%b want 0 0 0 1",
                     serIf.w, serIf.w_valid, serIf.busy, serIf.in_ready);
        end
        compareCount++;
        if (yCount !== 1) begin
            failCount++;
            $display("[TB] FAIL single_detect: got %0d detections want 1", yCount);
        end
    endtask

    // 8'h0F then 8'hF0 with valid held high: contiguous stream, ones run across the boundary.
    task automatic test_back_to_back();
        logic [2*NB-1:0] expStream;
        int              run;
        int              maxRun;
        expStream = {EXP_0F, EXP_F0};
        run       = 0;
        maxRun    = 0;
        @(negedge clk);
        serIf.in_valid = 1'b1;
        serIf.in_data  = 8'h0F;
        @(posedge clk);
        #1;
        serIf.in_data = 8'hF0;
        @(negedge clk);
        compareCount++;
        if (serIf.in_ready !== 1'b0 || serIf.w_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL b2b_latency: in_ready=%b w_valid=%b want 0 0", serIf.in_ready, serIf.w_valid);
        end
        for (int i = 0; i < 2*NB; i++) begin
            @(negedge clk);
            compareCount++;
            if (serIf.w !== expStream[2*NB-1-i] || serIf.w_valid !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL b2b_bit[%0d]: w=%b w_valid=%b want %b 1",
                         i, serIf.w, serIf.w_valid, expStream[2*NB-1-i]);
            end
            if (i == 0) begin
                compareCount++;
                if (serIf.in_ready !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL b2b_refill_ready: got %b want 1", serIf.in_ready);
                end
            end
            if (i == 1) serIf.in_valid = 1'b0;
            if (serIf.w === 1'b1) run++;
            else run = 0;
            if (run > maxRun) maxRun = run;
        end
        @(negedge clk);
        compareCount++;
        if (serIf.w_valid !== 1'b0 || serIf.busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL b2b_end: w_valid=%b busy=%b want 0 0", serIf.w_valid, serIf.busy);
        end
        compareCount++;
        if (maxRun !== MAX_RUN) begin
            failCount++;
            $display("[TB] FAIL b2b_ones_run: got %0d want %0d", maxRun, MAX_RUN);
        end
    endtask

    // Reset during bit 3 of 8'hFF, then 8'h80 must come out clean.
    task automatic test_reset_mid_word();
        @(negedge clk);
        serIf.in_valid = 1'b1;
        serIf.in_data  = 8'hFF;
        @(posedge clk);
        #1;
        serIf.in_valid = 1'b0;
        serIf.in_data  = 8'h00;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            compareCount++;
            if (serIf.w !== 1'b1 || serIf.w_valid !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL rst_mid_ff_bit[%0d]: w=%b w_valid=%b want 1 1", i, serIf.w, serIf.w_valid);
            end
        end
        #2 reset = 1'b1;
        #1;
        compareCount++;
        if (serIf.w !== 1'b0 || serIf.w_valid !== 1'b0 || serIf.busy !== 1'b0 || serIf.in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL rst_mid_immediate: w=%b w_valid=%b busy=%b in_ready=%b want 0 0 0 1",
                     serIf.w, serIf.w_valid, serIf.busy, serIf.in_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        compareCount++;
        if (serIf.w_valid !== 1'b0 || serIf.busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rst_mid_after: w_valid=%b busy=%b want 0 0", serIf.w_valid, serIf.busy);
        end
        serIf.in_valid = 1'b1;
        serIf.in_data  = 8'h80;
        @(posedge clk);
        #1;
        serIf.in_valid = 1'b0;
        serIf.in_data  = 8'h00;
        @(negedge clk);
        for (int i = 0; i < NB; i++) begin
            @(negedge clk);
            compareCount++;
            if (serIf.w !== EXP_80[NB-1-i] || serIf.w_valid !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL rst_mid_80_bit[%0d]: w=%b w_valid=%b want %b 1",
                         i, serIf.w, serIf.w_valid, EXP_80[NB-1-i]);
            end
        end
        @(negedge clk);
        compareCount++;
        if (serIf.w_valid !== 1'b0 || serIf.busy !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rst_mid_end: w_valid=%b busy=%b want 0 0", serIf.w_valid, serIf.busy);
        end
    endtask

    // Changing in_data with valid high while not ready must not alter the held word.
    task automatic test_ready_ignore();
        logic [2*NB-1:0] expStream;
        expStream = {EXP_A5, EXP_3C};
        @(negedge clk);
        serIf.in_valid = 1'b1;
        serIf.in_data  = 8'hA5;
        @(posedge clk);
        #1;
        serIf.in_data = 8'h3C;
        @(negedge clk);
        for (int i = 0; i < 2*NB; i++) begin
            @(negedge clk);
            compareCount++;
            if (serIf.w !== expStream[2*NB-1-i] || serIf.w_valid !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL ignore_bit[%0d]: w=%b w_valid=%b want %b 1",
                         i, serIf.w, serIf.w_valid, expStream[2*NB-1-i]);
            end
            if (i >= 1 && i <= NB-1) begin
                compareCount++;
                if (serIf.in_ready !== 1'b0) begin
                    failCount++;
                    $display("[TB] FAIL ignore_ready[%0d]: got %b want 0", i, serIf.in_ready);
                end
            end
            if (i >= 1 && i <= NB-2) serIf.in_data = 8'((i * 37) ^ 8'hC3);
            if (i == NB-1) begin
                serIf.in_valid = 1'b0;
                serIf.in_data  = 8'h00;
            end
        end
        @(negedge clk);
        compareCount++;
        if (serIf.w_valid !== 1'b0 || serIf.busy !== 1'b0 || serIf.in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL ignore_end: w_valid=%b busy=%b in_ready=%b want 0 0 1",
                     serIf.w_valid, serIf.busy, serIf.in_ready);
        end
    endtask

`ifdef SER_PARITY_EN
    // Parity: 8'hF1 ends with parity 1, 8'hF0 ends with parity 0.
    task automatic test_parity();
        for (int k = 0; k < 2; k++) begin
            logic [NB-1:0] expWord;
            expWord = (k == 0) ? EXP_F1 : EXP_F0;
            @(negedge clk);
            serIf.in_valid = 1'b1;
            serIf.in_data  = (k == 0) ? 8'hF1 : 8'hF0;
            @(posedge clk);
            #1;
            serIf.in_valid = 1'b0;
            serIf.in_data  = 8'h00;
            @(negedge clk);
            for (int i = 0; i < NB; i++) begin
                @(negedge clk);
                compareCount++;
                if (serIf.w !== expWord[NB-1-i] || serIf.w_valid !== 1'b1) begin
                    failCount++;
                    $display("[TB] FAIL parity_w%0d_bit[%0d]: w=%b w_valid=%b want %b 1",
                             k, i, serIf.w, serIf.w_valid, expWord[NB-1-i]);
                end
            end
            @(negedge clk);
            compareCount++;
            if (serIf.w_valid !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL parity_w%0d_end: w_valid=%b want 0", k, serIf.w_valid);
            end
        end
    endtask
`endif

    // Test sequence.
    initial begin
        reset          = 1'b1;
        serIf.in_valid = 1'b0;
        serIf.in_data  = '0;
        test_reset();
        test_single();
        test_back_to_back();
        test_reset_mid_word();
        test_ready_ignore();
`ifdef SER_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
